// File: rtl/grom8_mem_pkg.sv
`default_nettype none
// ============================================================================
// grom8_mem_pkg : shared RAM geometry, port indices and arbiter state encoding
// Rev 1.0
// ============================================================================
package grom8_mem_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/arb2_pick.sv
`default_nettype none
// ============================================================================
// arb2_pick : combinational two-way winner select (round-robin or fixed)
// Rev 1.0
// ============================================================================
module arb2_pick
  import grom8_mem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic gnt
);

  always_comb begin
    valid = req0 | req1;
    gnt   = PORT_CPU;
    if (req0 && req1) begin
      // on a tie the port that did not win last time goes next
      gnt = (FIXED_PRIO != 0) ? PORT_CPU : ~last_grant;
    end else if (req1) begin
      gnt = PORT_DMA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter : shares the single-port 4096x8 RAM between CPU and DMA ports
// Rev 1.0
// ============================================================================
module ram_arbiter
  import grom8_mem_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_memreq,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_memreq_q, mem_memreq_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        ack_q, ack_d;

  logic pick_valid;
  logic pick_gnt;

  arb2_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .gnt        (pick_gnt)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    mem_memreq_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ack_d        = 2'b00;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d        = pick_gnt;
          last_grant_d = pick_gnt;
          mem_memreq_d = 1'b1;
          mem_we_d     = pick_gnt ? we1    : we0;
          mem_addr_d   = pick_gnt ? addr1  : addr0;
          mem_wdata_d  = pick_gnt ? wdata1 : wdata0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // RAM samples the access at this edge; its data_out is valid next cycle
        ack_d[gnt_q] = 1'b1;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      gnt_q        <= PORT_CPU;
      last_grant_q <= PORT_DMA;
      mem_memreq_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      mem_memreq_q <= mem_memreq_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ack_q        <= ack_d;
    end
  end

  assign ack0       = ack_q[0];
  assign ack1       = ack_q[1];
  assign rdata      = mem_rdata;
  assign busy       = (state_q != IDLE);
  assign mem_memreq = mem_memreq_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_arbiter : directed bench, round-robin (d0) and fixed-priority (d1) DUTs
// Rev 1.0
// ============================================================================
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;

  logic        ack0_o   [2];
  logic        ack1_o   [2];
  logic        busy_o   [2];
  logic        memreq_o [2];
  logic        mwe_o    [2];
  logic [11:0] maddr_o  [2];
  logic [7:0]  mwdata_o [2];
  logic [7:0]  rdata_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] ram [4096];
    logic [7:0] ram_dout;

    // single-port RAM model with registered data_out
    always @(posedge clk) begin
      if (memreq_o[g]) begin
        if (mwe_o[g]) ram[maddr_o[g]] <= mwdata_o[g];
        else          ram_dout        <= ram[maddr_o[g]];
      end
    end

    ram_arbiter #(
      .ADDR_W     (12),
      .DATA_W     (8),
      .FIXED_PRIO (g)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req0       (req0),
      .we0        (we0),
      .addr0      (addr0),
      .wdata0     (wdata0),
      .ack0       (ack0_o[g]),
      .req1       (req1),
      .we1        (we1),
      .addr1      (addr1),
      .wdata1     (wdata1),
      .ack1       (ack1_o[g]),
      .rdata      (rdata_o[g]),
      .busy       (busy_o[g]),
      .mem_memreq (memreq_o[g]),
      .mem_we     (mwe_o[g]),
      .mem_addr   (maddr_o[g]),
      .mem_wdata  (mwdata_o[g]),
      .mem_rdata  (ram_dout)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit port, input bit we, input logic [11:0] addr, input logic [7:0] wd);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
    end
  endtask

  // Caller sits at the negedge where the request is already presented.
  task automatic txn_body(input bit port, input bit we, input logic [11:0] addr,
                          input logic [7:0] wd, input bit chk_rd, input logic [7:0] exp_rd);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("memreq d%0d a%0h", d, addr), 32'(memreq_o[d]), 32'd1);
      check_eq($sformatf("mem_we d%0d a%0h", d, addr), 32'(mwe_o[d]), 32'(we));
      check_eq($sformatf("mem_addr d%0d a%0h", d, addr), 32'(maddr_o[d]), 32'(addr));
      if (we) check_eq($sformatf("mem_wdata d%0d a%0h", d, addr), 32'(mwdata_o[d]), 32'(wd));
      check_eq($sformatf("early_ack d%0d a%0h", d, addr), 32'({ack1_o[d], ack0_o[d]}), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("ack d%0d a%0h", d, addr), 32'({ack1_o[d], ack0_o[d]}),
               port ? 32'd2 : 32'd1);
      check_eq($sformatf("memreq_off d%0d a%0h", d, addr), 32'(memreq_o[d]), 32'd0);
      if (chk_rd) check_eq($sformatf("rdata d%0d a%0h", d, addr), 32'(rdata_o[d]), 32'(exp_rd));
    end
    @(negedge clk);
    if (port) req1 = 1'b0; else req0 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("ack_end d%0d a%0h", d, addr), 32'({ack1_o[d], ack0_o[d]}), 32'd0);
      check_eq($sformatf("busy_end d%0d a%0h", d, addr), 32'(busy_o[d]), 32'd0);
    end
  endtask

  task automatic txn(input bit port, input bit we, input logic [11:0] addr,
                     input logic [7:0] wd, input bit chk_rd, input logic [7:0] exp_rd);
    drive(port, we, addr, wd);
    txn_body(port, we, addr, wd, chk_rd, exp_rd);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_rr, exp_fx, got;
    reset_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // reset held with a pending port-0 write
    drive(1'b0, 1'b1, 12'hD10, 8'h5A);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_memreq d%0d", d), 32'(memreq_o[d]), 32'd0);
      check_eq($sformatf("rst_ack0 d%0d", d), 32'(ack0_o[d]), 32'd0);
      check_eq($sformatf("rst_busy d%0d", d), 32'(busy_o[d]), 32'd0);
      check_eq($sformatf("rst_addr d%0d", d), 32'(maddr_o[d]), 32'd0);
      check_eq($sformatf("rst_wdata d%0d", d), 32'(mwdata_o[d]), 32'd0);
    end
    reset_n = 1'b1;
    txn_body(1'b0, 1'b1, 12'hD10, 8'h5A, 1'b0, 8'h00);
    txn(1'b0, 1'b0, 12'hD10, 8'h00, 1'b1, 8'h5A);

    // address span extremes
    txn(1'b0, 1'b1, 12'hFFF, 8'hC3, 1'b0, 8'h00);
    txn(1'b0, 1'b1, 12'h000, 8'h3C, 1'b0, 8'h00);
    txn(1'b0, 1'b0, 12'hFFF, 8'h00, 1'b1, 8'hC3);
    txn(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h3C);

    // contention from reset: port 0 reads 0xD10, port 1 writes 0xF00=0x33
    apply_reset();
    drive(1'b0, 1'b0, 12'hD10, 8'h00);
    drive(1'b1, 1'b1, 12'hF00, 8'h33);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      case (k)
        2, 8:   begin exp_rr = 2'b01; exp_fx = 2'b01; end
        5, 11:  begin exp_rr = 2'b10; exp_fx = 2'b01; end
        14:     begin exp_rr = 2'b10; exp_fx = 2'b10; end
        default: begin exp_rr = 2'b00; exp_fx = 2'b00; end
      endcase
      for (int d = 0; d < 2; d++) begin
        got = {ack1_o[d], ack0_o[d]};
        check_eq($sformatf("arb_ack d%0d k%0d", d, k), 32'(got), (d == 0) ? 32'(exp_rr) : 32'(exp_fx));
        if (got == 2'b01) check_eq($sformatf("arb_rdata d%0d k%0d", d, k), 32'(rdata_o[d]), 32'h5A);
      end
      if (k == 12) req0 = 1'b0;
      if (k == 15) req1 = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("arb_busy_end d%0d", d), 32'(busy_o[d]), 32'd0);

    // port 0 reads what port 1 wrote; port 1 churns during ISSUE/RESP
    drive(1'b0, 1'b0, 12'hF00, 8'h00);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("xp_addr d%0d", d), 32'(maddr_o[d]), 32'hF00);
    drive(1'b1, 1'b1, 12'hF00, 8'hEE);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("xp_ack d%0d", d), 32'({ack1_o[d], ack0_o[d]}), 32'd1);
      check_eq($sformatf("xp_rdata d%0d", d), 32'(rdata_o[d]), 32'h33);
    end
    req1 = 1'b0; addr1 = 12'h123; wdata1 = 8'h99;
    @(negedge clk);
    req0 = 1'b0;
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("xp_ack_end d%0d", d), 32'({ack1_o[d], ack0_o[d]}), 32'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("xp_no_grant d%0d", d), 32'(memreq_o[d]), 32'd0);
    txn(1'b0, 1'b0, 12'hF00, 8'h00, 1'b1, 8'h33);

    // reset pulsed while a port-1 write is in ISSUE
    drive(1'b1, 1'b1, 12'h0AA, 8'h77);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("mid_issue d%0d", d), 32'(memreq_o[d]), 32'd1);
    reset_n = 1'b0;
    #1;
    req1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("mid_busy d%0d", d), 32'(busy_o[d]), 32'd0);
      check_eq($sformatf("mid_memreq d%0d", d), 32'(memreq_o[d]), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        check_eq($sformatf("mid_no_ack d%0d", d), 32'({ack1_o[d], ack0_o[d]}), 32'd0);
    end
    txn(1'b1, 1'b1, 12'h0AB, 8'h11, 1'b0, 8'h00);
    txn(1'b1, 1'b0, 12'h0AB, 8'h00, 1'b1, 8'h11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
